// File: rtl/bp_commit_trace_collector_if.sv
// Trace packet channel between the commit trace collector and the trace sink.
// master: collector side (drives the packet and trace_v_o, samples trace_ready_i)
// slave : sink side (samples the packet, drives trace_ready_i)
interface bp_commit_trace_collector_if #(
  parameter int unsigned vaddr_width_p = 39,
  parameter int unsigned instr_width_p = 32,
  parameter int unsigned dword_width_p = 64
);
  logic                     trace_v_o;
  logic                     trace_ready_i;
  logic [vaddr_width_p-1:0] trace_pc_o;
  logic [instr_width_p-1:0] trace_instr_o;
  logic [30:0]              trace_itag_o;
  logic                     trace_rd_w_v_o;
  logic [4:0]               trace_rd_addr_o;
  logic [dword_width_p-1:0] trace_rd_data_o;

  modport master (
    output trace_v_o, trace_pc_o, trace_instr_o, trace_itag_o,
           trace_rd_w_v_o, trace_rd_addr_o, trace_rd_data_o,
    input  trace_ready_i
  );

  modport slave (
    input  trace_v_o, trace_pc_o, trace_instr_o, trace_itag_o,
           trace_rd_w_v_o, trace_rd_addr_o, trace_rd_data_o,
    output trace_ready_i
  );
endinterface

// File: rtl/bp_commit_trace_collector.sv
// Commit trace collector. Pairs each in-order committed instruction with its
// later in-order rd writeback, tags it with a 31-bit itag, and presents
// complete packets to the trace sink through a small register FIFO so that
// commit never stalls. A commit that finds no room is dropped, counted, and
// latches the collector into OVERFLOW until reset.
//
// Ports:
//   clk_i, reset_n_i           clock, async active-low reset
//   freeze_i                   masks commit_v_i
//   commit_*                   commit stream (pc, instr, rd write valid/addr)
//   wb_v_i, wb_data_i          writeback stream, program order of rd writers
//   trace (master modport)     packet valid/ready channel to the sink
//   overflow_o                 sticky, trace is incomplete
//   drop_cnt_o                 saturating count of dropped commits
module bp_commit_trace_collector #(
  parameter int unsigned vaddr_width_p    = 39,
  parameter int unsigned instr_width_p    = 32,
  parameter int unsigned dword_width_p    = 64,
  parameter int unsigned fifo_els_p       = 4,
  parameter int unsigned drop_cnt_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        freeze_i,
  input  logic                        commit_v_i,
  input  logic [vaddr_width_p-1:0]    commit_pc_i,
  input  logic [instr_width_p-1:0]    commit_instr_i,
  input  logic                        commit_rd_w_v_i,
  input  logic [4:0]                  commit_rd_addr_i,
  input  logic                        wb_v_i,
  input  logic [dword_width_p-1:0]    wb_data_i,
  bp_commit_trace_collector_if.master trace,
  output logic                        overflow_o,
  output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

  localparam int unsigned ptr_w_lp = $clog2(fifo_els_p);

  typedef logic [ptr_w_lp-1:0]         ptr_t;
  typedef logic [ptr_w_lp:0]           cnt_t;
  typedef logic [drop_cnt_width_p-1:0] drop_t;
  typedef enum logic {e_run, e_overflow} state_e;

  logic [vaddr_width_p-1:0] pc_r    [fifo_els_p];
  logic [instr_width_p-1:0] instr_r [fifo_els_p];
  logic [30:0]              itag_q  [fifo_els_p];
  logic [4:0]               rd_addr_r [fifo_els_p];
  logic [dword_width_p-1:0] data_r  [fifo_els_p];
  logic [fifo_els_p-1:0]    rd_w_v_r;
  logic [fifo_els_p-1:0]    data_v_r;

  ptr_t   rd_ptr_r, wr_ptr_r;
  cnt_t   cnt_r;
  logic [30:0] itag_r;
  state_e state_r;
  logic   overflow_r;
  drop_t  drop_cnt_r;

  logic eff_commit, eff_rd_w;
  logic head_complete, trace_v, deq, room, enq, drop;
  logic pend_found;
  ptr_t pend_idx, scan_idx;
  logic wb_fifo, wb_bypass;

  assign eff_commit    = commit_v_i & ~freeze_i;
  assign eff_rd_w      = commit_rd_w_v_i & (commit_rd_addr_i != 5'd0);
  assign head_complete = ~rd_w_v_r[rd_ptr_r] | data_v_r[rd_ptr_r];
  assign trace_v       = (cnt_r != '0) & head_complete;
  assign deq           = trace_v & trace.trace_ready_i;
  // A dequeue in the same cycle frees the slot the write pointer lands on.
  assign room          = (cnt_r != cnt_t'(fifo_els_p)) | deq;
  assign enq           = eff_commit & (state_r == e_run) & room;
  assign drop          = eff_commit & ~enq;

  // Oldest occupied entry still waiting for its writeback. Writebacks arrive
  // in the order of rd-writing commits, so the first such entry from the head
  // is always the one the next writeback belongs to.
  always_comb begin
    pend_found = 1'b0;
    pend_idx   = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < fifo_els_p; i++) begin
      scan_idx = rd_ptr_r + ptr_t'(i);
      if (!pend_found && (i < 32'(cnt_r)) && rd_w_v_r[scan_idx] && !data_v_r[scan_idx]) begin
        pend_found = 1'b1;
        pend_idx   = scan_idx;
      end
    end
  end

  // With nothing pending in the FIFO, a writeback arriving alongside an
  // rd-writing enqueue belongs to that new entry.
  assign wb_fifo   = wb_v_i & pend_found;
  assign wb_bypass = wb_v_i & ~pend_found & enq & eff_rd_w;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < fifo_els_p; i++) begin
        pc_r[i]      <= '0;
        instr_r[i]   <= '0;
        itag_q[i]    <= '0;
        rd_addr_r[i] <= '0;
        data_r[i]    <= '0;
      end
      rd_w_v_r <= '0;
      data_v_r <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (enq) begin
        pc_r[wr_ptr_r]      <= commit_pc_i;
        instr_r[wr_ptr_r]   <= commit_instr_i;
        itag_q[wr_ptr_r]    <= itag_r;
        rd_addr_r[wr_ptr_r] <= commit_rd_addr_i;
        rd_w_v_r[wr_ptr_r]  <= eff_rd_w;
        data_r[wr_ptr_r]    <= wb_bypass ? wb_data_i : '0;
        data_v_r[wr_ptr_r]  <= wb_bypass;
        wr_ptr_r            <= wr_ptr_r + ptr_t'(1);
      end
      if (wb_fifo) begin
        data_r[pend_idx]   <= wb_data_i;
        data_v_r[pend_idx] <= 1'b1;
      end
      if (deq) begin
        rd_ptr_r <= rd_ptr_r + ptr_t'(1);
      end
      cnt_r <= cnt_r + cnt_t'(enq) - cnt_t'(deq);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_run;
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
      itag_r     <= '0;
    end else begin
      // Dropped commits still consume an itag so the sink sees the gap.
      if (eff_commit) begin
        itag_r <= itag_r + 31'd1;
      end
      if (drop && (drop_cnt_r != '1)) begin
        drop_cnt_r <= drop_cnt_r + drop_t'(1);
      end
      case (state_r)
        e_run: begin
          if (drop) begin
            state_r    <= e_overflow;
            overflow_r <= 1'b1;
          end
        end
        e_overflow: begin
          state_r <= e_overflow;
        end
        default: begin
          state_r <= e_run;
        end
      endcase
    end
  end

  assign trace.trace_v_o       = trace_v;
  assign trace.trace_pc_o      = pc_r[rd_ptr_r];
  assign trace.trace_instr_o   = instr_r[rd_ptr_r];
  assign trace.trace_itag_o    = itag_q[rd_ptr_r];
  assign trace.trace_rd_w_v_o  = rd_w_v_r[rd_ptr_r];
  assign trace.trace_rd_addr_o = rd_addr_r[rd_ptr_r];
  assign trace.trace_rd_data_o = data_r[rd_ptr_r];
  assign overflow_o            = overflow_r;
  assign drop_cnt_o            = drop_cnt_r;

endmodule
